// File: rtl/seq_alu_pkg.sv
// Shared constants and types for the sequential ALU: base op codes, M-extension
// funct3 codes, FSM state type and operand-signedness helpers.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider on
// operand magnitudes, one bit per cycle for WIDTH cycles, signs fixed up at the end.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic                   busy_q, busy_d;
  logic [SHW-1:0]         count_q, count_d;
  logic [2:0]             f3_q, f3_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       x_q, x_d;       // multiplier bits, then quotient bits
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       dvsr_q, dvsr_d;
  logic                   neg_q, neg_d;
  logic                   rneg_q, rneg_d;

  logic                   a_sgn, b_sgn;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         shifted, trial;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix, rem_fix;

  assign a_sgn = a_i[WIDTH-1] & f3_a_signed(funct3_i);
  assign b_sgn = b_i[WIDTH-1] & f3_b_signed(funct3_i);
  assign a_mag = a_sgn ? -a_i : a_i;
  assign b_mag = b_sgn ? -b_i : b_i;

  assign shifted = {rem_q, x_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_comb begin
    // NOTE: every next-state value starts from its register so no path can infer a latch.
    busy_d  = busy_q;
    count_d = count_q;
    f3_d    = f3_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    x_d     = x_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    if (abort_i) begin
      busy_d  = 1'b0;
      count_d = '0;
    end else if (start_i) begin
      busy_d  = 1'b1;
      count_d = '0;
      f3_d    = funct3_i;
      prod_d  = '0;
      mcand_d = {{WIDTH{1'b0}}, a_mag};
      rem_d   = '0;
      dvsr_d  = b_mag;
      x_d     = funct3_i[2] ? a_mag : b_mag;
      // A zero divisor keeps the all-ones quotient unsigned; signed overflow wraps to a naturally.
      neg_d   = funct3_i[2] ? ((a_sgn ^ b_sgn) & (|b_i)) : (a_sgn ^ b_sgn);
      rneg_d  = a_sgn;
    end else if (busy_q) begin
      count_d = count_q + 1'b1;
      if (count_q == LAST_STEP) busy_d = 1'b0;
      if (f3_q[2]) begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (x_q[0]) prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        x_d     = x_q >> 1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      f3_q    <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      f3_q    <= f3_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  // The final step is taken combinationally so the owner can capture it on the WIDTH-th BUSY edge.
  assign done_o   = busy_q && (count_q == LAST_STEP);
  assign prod_fix = neg_q ? -prod_d : prod_d;
  assign quo_fix  = neg_q ? -x_d : x_d;
  assign rem_fix  = rneg_q ? -rem_d : rem_d;

  always_comb begin
    result_o = '0;
    unique case (f3_q)
      F3_MUL:                       result_o = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              result_o = quo_fix;
      default:                      result_o = rem_fix;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake and IDLE/BUSY/DONE control.
// Define SEQ_ALU_MULDIV_EN to add the iterative M-extension multiply/divide unit.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  input  logic             flush
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_res, base_res;

  function automatic logic [WIDTH-1:0] base_alu(input logic [3:0] code,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    unique case (code)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLL:  return x << sh;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: return {{(WIDTH-1){1'b0}}, (x < y)};
      OP_XOR:  return x ^ y;
      OP_SRL:  return x >> sh;
      OP_SRA:  return WIDTH'($signed(x) >>> sh);
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      default: return '0;
    endcase
  endfunction

  assign alu_res = base_alu(op[3:0], a, b);

`ifdef SEQ_ALU_MULDIV_EN
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign base_res = alu_res;

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk      (clk),
    .rst      (reset),
    .start_i  (md_start),
    .abort_i  (flush),
    .funct3_i (op[2:0]),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  // Without the M unit, extension ops retire as base ops with a zero result.
  assign base_res = op[4] ? '0 : alu_res;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef SEQ_ALU_MULDIV_EN
    md_start = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (op[4]) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            result_d = base_res;
            zero_d   = ~|base_res;
            state_d  = ST_DONE;
          end
`else
          result_d = base_res;
          zero_d   = ~|base_res;
          state_d  = ST_DONE;
`endif
        end
      end
      ST_BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (md_done) begin
          result_d = md_result;
          zero_d   = ~|md_result;
          state_d  = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, including a request accepted in the same cycle.
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      zero_d   = zero_q;
`ifdef SEQ_ALU_MULDIV_EN
      md_start = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at request time and
// compared with latency when out_valid appears; covers hold, flush and reset abort.
module tb_seq_alu;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             flush;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] xs, ys;
    logic [63:0]        xu, yu, p;
    logic signed [31:0] sx, sy;
    logic               ovf;
    xs  = {{32{x[31]}}, x};
    ys  = {{32{y[31]}}, y};
    xu  = {32'b0, x};
    yu  = {32'b0, y};
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (!o[4]) begin
      case (o[3:0])
        4'b0000: return x + y;
        4'b1000: return x - y;
        4'b0001: return x << y[4:0];
        4'b0010: return (sx < sy) ? 32'd1 : 32'd0;
        4'b0011: return (x < y) ? 32'd1 : 32'd0;
        4'b0100: return x ^ y;
        4'b0101: return x >> y[4:0];
        4'b1101: return sx >>> y[4:0];
        4'b0110: return x | y;
        4'b0111: return x & y;
        default: return 32'd0;
      endcase
    end
`ifdef SEQ_ALU_MULDIV_EN
    case (o[2:0])
      3'b000: begin p = xu * yu; return p[31:0]; end
      3'b001: begin p = xs * ys; return p[63:32]; end
      3'b010: begin p = xs * $signed(yu); return p[63:32]; end
      3'b011: begin p = xu * yu; return p[63:32]; end
      3'b100: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : sx / sy;
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: return (y == 0) ? x : ovf ? 32'd0 : sx % sy;
      default: return (y == 0) ? x : x % y;
    endcase
`else
    return 32'd0;
`endif
  endfunction

  function automatic int exp_lat(input logic [4:0] o);
`ifdef SEQ_ALU_MULDIV_EN
    return o[4] ? WIDTH + 1 : 1;
`else
    return 1;
`endif
  endfunction

  // Issue one op, wait for its result, hold it for 'hold' cycles, then release.
  task automatic run_op(input string name, input logic [4:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    check({name, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    op       = op_v;
    a        = a_v;
    b        = b_v;
    in_valid = 1'b1;
    e.name = name;
    e.res  = model(op_v, a_v, b_v);
    e.lat  = exp_lat(op_v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "/out_valid"}, 32'(out_valid), 32'd1);
    e = sb.pop_front();
    check({e.name, "/latency"}, 32'(lat), 32'(e.lat));
    check({e.name, "/result"}, result, e.res);
    check({e.name, "/zero"}, 32'(zero), (e.res == 32'd0) ? 32'd1 : 32'd0);
    check({e.name, "/in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({e.name, "/hold_result"}, result, e.res);
      check({e.name, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({e.name, "/hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({e.name, "/valid_drop"}, 32'(out_valid), 32'd0);
    check({e.name, "/in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  // Start a DIVU, abort it at cycle 10 with flush or reset, and watch for a stray result.
  task automatic abort_divu(input bit use_reset);
    string tag;
    int    seen;
    tag = use_reset ? "reset_abort" : "flush_abort";
    @(negedge clk);
    op       = 5'b10101;
    a        = 32'd1000;
    b        = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check({tag, "/no_out_valid"}, 32'(seen), 32'd0);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    if (use_reset) begin
      check({tag, "/result_cleared"}, result, 32'd0);
      check({tag, "/zero_set"}, 32'(zero), 32'd1);
    end
  endtask

  logic [3:0] base_codes[10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                                 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/result", result, 32'd0);
    check("reset/zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset/in_ready", 32'(in_ready), 32'd1);

    run_op("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("sra",     5'b01101, 32'h8000_0000, 32'h0000_0024, 0);
    run_op("slt",     5'b00010, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("sltu",    5'b00011, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("sub_zero", 5'b01000, 32'h1234_5678, 32'h1234_5678, 0);
    run_op("sll",     5'b00001, 32'h0000_00F1, 32'h0000_001F, 0);
    run_op("srl",     5'b00101, 32'h8000_0000, 32'h0000_0024, 0);
    run_op("xor",     5'b00100, 32'hA5A5_0F0F, 32'hFFFF_0000, 0);
    run_op("or",      5'b00110, 32'hA000_0001, 32'h0500_0010, 0);
    run_op("and",     5'b00111, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 0);
    run_op("bad_code", 5'b01001, 32'hFFFF_FFFF, 32'h0000_0001, 0);

    run_op("mulh",    5'b10001, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mul",     5'b10000, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    run_op("mulhsu",  5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu",   5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("div_by0", 5'b10100, 32'hFFFF_FFF9, 32'h0000_0000, 0);
    run_op("divu_by0", 5'b10101, 32'h0000_0005, 32'h0000_0000, 0);
    run_op("remu_by0", 5'b10111, 32'h0000_0005, 32'h0000_0000, 0);
    run_op("remu",    5'b10111, 32'd100, 32'd7, 0);

    for (int i = 0; i < 8; i++) begin
      run_op("rand_base", {1'b0, base_codes[$urandom_range(9)]}, $urandom, $urandom, 0);
    end

    run_op("hold_add", 5'b00000, 32'd3, 32'd4, 5);

    abort_divu(1'b0);
    run_op("add_after_flush", 5'b00000, 32'd1, 32'd1, 0);
    abort_divu(1'b1);
    run_op("add_after_reset", 5'b00000, 32'd1, 32'd1, 0);

    // Flush in the same cycle as a request must cancel the request.
    @(negedge clk);
    op       = 5'b00000;
    a        = 32'd9;
    b        = 32'd9;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_accept/out_valid", 32'(out_valid), 32'd0);
    check("flush_vs_accept/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("flush_vs_accept/out_valid_late", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width, taken from b[SHW-1:0].
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  5  operation code; op[4]=0 selects base ALU ops, op[4]=1 selects M-extension ops with funct3 in op[2:0].
REQ-008 a, b  input  WIDTH  operands, sampled on handshake.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  registered flag: result == 0.
REQ-013 flush  input  1  synchronous abort of any in-flight operation.

Function
REQ-014 Base ops (op[4]=0) SHALL use these codes on op[3:0]: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA (true arithmetic, sign-filled), 0110 OR, 0111 AND; other codes yield 0.
REQ-015 Request accepted when in_valid && in_ready; operands and op SHALL be captured that edge.
REQ-016 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-017 Base op: IDLE->DONE on accept; out_valid asserted the next cycle (latency 1).
REQ-018 M op: IDLE->BUSY on accept; BUSY iterates one bit per cycle for WIDTH cycles, then ->DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-019 DONE holds result, zero and out_valid stable until out_ready=1; then ->IDLE, out_valid deasserts the next cycle.
REQ-020 No accept in DONE: back-to-back throughput for base ops is one result per 2 cycles.
REQ-021 M funct3: 000 MUL (low WIDTH bits), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-022 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
REQ-023 Signed overflow (a = most-negative, b = -1): DIV -> a; REM -> 0.
REQ-024 Signed divide: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
REQ-025 zero SHALL be computed from the final result, registered with it.
REQ-026 flush=1 in any state SHALL force IDLE next cycle, drop out_valid, discard the result; flush wins over simultaneous accept.

Reset
REQ-027 On reset: state IDLE, out_valid=0, result=0, zero=1, iteration counter=0; in_ready=1 once reset deasserts.
REQ-028 Reset mid-BUSY or in DONE SHALL abandon the operation with no out_valid produced.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined: M ops per REQ-018..REQ-024.
REQ-030 Macro absent: no multiply/divide hardware; any op[4]=1 completes as a base op with latency 1 and result 0; BUSY unreachable.

Structure
REQ-031 Package seq_alu_pkg SHALL hold the op-code constants, the M funct3 constants and the FSM state typedef.
REQ-032 Sub-module seq_alu_muldiv SHALL implement the iterative shift-add multiplier and restoring divider with start/done, instantiated only under SEQ_ALU_MULDIV_EN.

Verification
REQ-033 ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, zero=0, out_valid one cycle after accept.
REQ-034 SRA a=0x80000000, b=0x24 (shift 4) -> 0xF8000000; SLT a=0xFFFFFFFF, b=0 -> 1; SLTU same operands -> 0.
REQ-035 MULH a=0x80000000, b=0x80000000 -> 0x40000000, out_valid exactly 33 cycles after accept.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
REQ-037 Hold out_ready=0 for 5 cycles after ADD 3+4 -> result 7 stable, in_ready=0 throughout; accept on release, in_ready=1 the next cycle.
REQ-038 Assert flush or reset at cycle 10 of a DIVU -> no out_valid; next ADD 1+1 returns 2 normally.
